// File: rtl/op_queue_reader.sv
// Consumer side of the checkpointed op queue: streams GROUP_LEN-op groups downstream,
// committing on grp_done and rewinding/replaying on grp_fail. Optional macro: READER_TIMEOUT_EN.
`ifndef OP_SIZE
`define OP_SIZE 8
`endif

module op_queue_reader #(
  parameter int GROUP_LEN   = 4,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                q_empty,
  input  logic [`OP_SIZE-1:0] q_data,
  output logic                q_pop,
  output logic                q_next,
  output logic                q_reset,
  output logic                op_valid,
  output logic [`OP_SIZE-1:0] op_data,
  input  logic                op_ready,
  input  logic                grp_done,
  input  logic                grp_fail,
  output logic                busy,
  output logic                error
);

  localparam int CNT_W = $clog2(GROUP_LEN + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(GROUP_LEN - 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    REWIND   = 3'd3,
    HALT     = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] op_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             op_valid_q;
  logic             busy_q;
  logic             error_q;
  logic             accept;
  logic             ack_done;
  logic             ack_fail;
  logic             can_retry;
  logic             timeout_hit;

`ifdef READER_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(ACK_TIMEOUT);
  logic [TO_W-1:0] to_cnt;

  // Ack watchdog: zero whenever outside WAIT_ACK, so it starts from zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != WAIT_ACK) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIMIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end

  assign timeout_hit = (state == WAIT_ACK) && (to_cnt == TO_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // A real ack in the timeout cycle wins over the timeout; fail wins over done.
  assign accept    = op_valid_q & op_ready;
  assign ack_fail  = (state == WAIT_ACK) && (grp_fail || (timeout_hit && !grp_done));
  assign ack_done  = (state == WAIT_ACK) && grp_done && !grp_fail;
  assign can_retry = (retry_cnt < RTY_MAX);

  assign q_pop    = accept;
  assign q_next   = ack_done;
  assign q_reset  = ack_fail && can_retry;
  assign op_valid = op_valid_q;
  assign op_data  = op_valid_q ? q_data : {`OP_SIZE{1'b0}};
  assign busy     = busy_q;
  assign error    = error_q;

  // Group sequencing FSM with registered valid/busy/error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_cnt     <= '0;
      retry_cnt  <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!q_empty) begin
            state      <= ISSUE;
            op_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (accept && (op_cnt == LAST_OP)) begin
            op_cnt     <= '0;
            state      <= WAIT_ACK;
            op_valid_q <= 1'b0;
          end else if (accept) begin
            op_cnt <= op_cnt + CNT_W'(1);
          end else begin
            op_cnt <= op_cnt;
          end
        end
        WAIT_ACK: begin
          if (ack_fail && can_retry) begin
            retry_cnt <= retry_cnt + RTY_W'(1);
            state     <= REWIND;
          end else if (ack_fail) begin
            error_q <= 1'b1;
            state   <= HALT;
          end else if (ack_done) begin
            retry_cnt <= '0;
            state     <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            state <= WAIT_ACK;
          end
        end
        REWIND: begin
          // q_data has settled on the checkpoint entry by now.
          state      <= ISSUE;
          op_valid_q <= 1'b1;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state      <= IDLE;
          op_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_queue_reader.sv
// Directed bench for op_queue_reader with a small checkpointed-queue model as stimulus source.
`ifndef OP_SIZE
`define OP_SIZE 8
`endif

module tb_op_queue_reader;

  logic                clk = 1'b0;
  logic                rst;
  logic                q_empty;
  logic [`OP_SIZE-1:0] q_data;
  logic                q_pop, q_next, q_reset;
  logic                op_valid;
  logic [`OP_SIZE-1:0] op_data;
  logic                op_ready, grp_done, grp_fail;
  logic                busy, error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [64];
  logic [7:0] pat [4];
  int rd_ptr, chk_ptr, wr_ptr;

  always #5 clk = ~clk;

  op_queue_reader #(.GROUP_LEN(4), .MAX_RETRY(3), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_data(q_data),
    .q_pop(q_pop), .q_next(q_next), .q_reset(q_reset),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .grp_done(grp_done), .grp_fail(grp_fail), .busy(busy), .error(error)
  );

  // Queue model: read pointer, checkpoint, bench-controlled write pointer.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= 0;
      chk_ptr <= 0;
    end else if (q_pop) begin
      rd_ptr <= rd_ptr + 1;
    end else if (q_next) begin
      chk_ptr <= rd_ptr;
    end else if (q_reset) begin
      rd_ptr <= chk_ptr;
    end
  end

  assign q_data  = mem[rd_ptr % 64];
  assign q_empty = ((wr_ptr - chk_ptr) < 4);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_group(input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk({tag, "_valid"}, op_valid, 1);
      chk({tag, "_data"}, op_data, pat[k]);
      chk({tag, "_pop"}, q_pop, 1);
    end
  endtask

  initial begin
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 64; i++) mem[i] = pat[i % 4];
    rst = 1'b1; wr_ptr = 0; op_ready = 1'b0; grp_done = 1'b0; grp_fail = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", op_valid, 0);
    chk("rst_pop", q_pop, 0);
    chk("rst_next", q_next, 0);
    chk("rst_reset", q_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_data", op_data, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_empty_busy", busy, 0);

    // Commit path
    wr_ptr = 4; op_ready = 1'b1;
    issue_group("commit");
    @(negedge clk); grp_done = 1'b1; #1;
    chk("commit_wait_valid", op_valid, 0);
    chk("commit_wait_busy", busy, 1);
    chk("commit_next", q_next, 1);
    chk("commit_noreset", q_reset, 0);
    @(negedge clk); grp_done = 1'b0; #1;
    chk("commit_idle_busy", busy, 0);
    chk("commit_next_off", q_next, 0);

    // Backpressure on op 2
    wr_ptr = 8;
    @(negedge clk); #1;
    chk("bp_op1", op_data, 8'h11);
    chk("bp_op1_pop", q_pop, 1);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); op_ready = 1'b0; #1;
      chk("bp_stall_valid", op_valid, 1);
      chk("bp_stall_data", op_data, 8'h22);
      chk("bp_stall_pop", q_pop, 0);
    end
    @(negedge clk); op_ready = 1'b1; #1;
    chk("bp_rel_data", op_data, 8'h22);
    chk("bp_rel_pop", q_pop, 1);
    @(negedge clk); #1;
    chk("bp_op3", op_data, 8'h33);
    @(negedge clk); #1;
    chk("bp_op4", op_data, 8'h44);
    chk("bp_op4_pop", q_pop, 1);

    // Replay after grp_fail
    @(negedge clk); grp_fail = 1'b1; #1;
    chk("replay_reset", q_reset, 1);
    chk("replay_nonext", q_next, 0);
    @(negedge clk); grp_fail = 1'b0; #1;
    chk("rewind_valid", op_valid, 0);
    chk("rewind_busy", busy, 1);
    chk("rewind_reset_off", q_reset, 0);
    chk("rewind_pop", q_pop, 0);
    issue_group("replay");
    @(negedge clk); grp_done = 1'b1; #1;
    chk("replay_next", q_next, 1);
    @(negedge clk); grp_done = 1'b0; #1;
    chk("replay_idle_busy", busy, 0);

    // Retry exhaustion: three replays, fourth fail halts
    wr_ptr = 12;
    for (int r = 0; r < 4; r++) begin
      issue_group("exh");
      @(negedge clk); grp_fail = 1'b1; #1;
      chk("exh_reset", q_reset, (r < 3) ? 1 : 0);
      chk("exh_error_pre", error, 0);
      if (r < 3) begin
        @(negedge clk); grp_fail = 1'b0; #1;
        chk("exh_rewind_valid", op_valid, 0);
      end
    end
    @(negedge clk); grp_fail = 1'b0; #1;
    chk("halt_error", error, 1);
    chk("halt_busy", busy, 1);
    chk("halt_valid", op_valid, 0);
    @(negedge clk); grp_fail = 1'b1; #1;
    chk("halt_no_reset", q_reset, 0);
    chk("halt_no_pop", q_pop, 0);
    @(negedge clk); grp_fail = 1'b0; grp_done = 1'b1; #1;
    chk("halt_no_next", q_next, 0);
    chk("halt_error_held", error, 1);
    @(negedge clk); grp_done = 1'b0; rst = 1'b1; wr_ptr = 0; #1;
    chk("halt_rst_error", error, 0);
    chk("halt_rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // Fail beats done when both arrive together
    @(negedge clk); #1;
    chk("prio_idle", busy, 0);
    wr_ptr = 4;
    issue_group("prio");
    @(negedge clk); grp_done = 1'b1; grp_fail = 1'b1; #1;
    chk("prio_reset", q_reset, 1);
    chk("prio_nonext", q_next, 0);
    @(negedge clk); grp_done = 1'b0; grp_fail = 1'b0; #1;
    chk("prio_rewind_valid", op_valid, 0);
    chk("prio_rewind_busy", busy, 1);

    // Async reset mid-ISSUE after two ops
    @(negedge clk); #1;
    chk("mid_op1", op_data, 8'h11);
    @(negedge clk); #1;
    chk("mid_op2", op_data, 8'h22);
    @(negedge clk); #1;
    chk("mid_op3_valid", op_valid, 1);
    rst = 1'b1; wr_ptr = 0; #1;
    chk("mid_rst_valid", op_valid, 0);
    chk("mid_rst_pop", q_pop, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", op_data, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_idle", busy, 0);
    wr_ptr = 4;
    issue_group("restart");
    @(negedge clk); #1;
    chk("restart_wait_valid", op_valid, 0);
    chk("restart_wait_busy", busy, 1);
    chk("restart_wait_pop", q_pop, 0);

    // Ack timeout (this check cycle is WAIT_ACK cycle 0)
`ifdef READER_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      @(negedge clk); #1;
      chk("to_before", q_reset, 0);
    end
    @(negedge clk); #1;
    chk("to_reset", q_reset, 1);
    @(negedge clk); #1;
    chk("to_rewind_valid", op_valid, 0);
    issue_group("to_replay");
`else
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
    end
    #1;
    chk("noto_busy", busy, 1);
    chk("noto_valid", op_valid, 0);
    chk("noto_reset", q_reset, 0);
`endif
    @(negedge clk); grp_done = 1'b1; #1;
    chk("final_next", q_next, 1);
    @(negedge clk); grp_done = 1'b0; #1;
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/op_queue_reader.md
Name: op_queue_reader

Overview:
- Consumer side of the checkpointed op queue (`storage_queue`).
- Drives the queue's pop / next (checkpoint) / reset (rewind) controls and streams ops to a downstream execute unit over a valid/ready handshake, in fixed-size groups.
- Each group is committed (checkpoint advanced) on a downstream ack, or rewound and replayed on a downstream fail, up to a retry limit.

Parameters:
- GROUP_LEN, 4: ops per group. Must equal the queue's empty threshold (empty deasserts at ≥4 entries beyond checkpoint).
- MAX_RETRY, 3: replays allowed per group before error.
- ACK_TIMEOUT, 64: WAIT_ACK cycle limit; used only with READER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- q_empty  in  1  queue empty flag (fewer than GROUP_LEN entries beyond checkpoint)
- q_data  in  `OP_SIZE  queue head op
- q_pop  out  1  pop head (advance read pointer)
- q_next  out  1  commit checkpoint at current read pointer
- q_reset  out  1  rewind read pointer to checkpoint
- op_valid  out  1  op_data valid to downstream
- op_data  out  `OP_SIZE  op to downstream
- op_ready  in  1  downstream accepts op
- grp_done  in  1  downstream commits group (pulse)
- grp_fail  in  1  downstream aborts group (pulse)
- busy  out  1  state != IDLE
- error  out  1  sticky: retry limit exceeded

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; op_cnt=0, retry_cnt=0, error=0.
  - All outputs 0.
- States: IDLE, ISSUE, WAIT_ACK, REWIND, HALT.
- IDLE: if !q_empty, go to ISSUE next cycle. Otherwise stay.
- ISSUE:
  - op_valid=1; op_data=q_data (combinational passthrough).
  - q_pop = op_valid & op_ready, in the same cycle as acceptance. The next op appears on q_data the following cycle.
  - op_cnt (width clog2(GROUP_LEN+1)) increments per accepted op.
  - On the GROUP_LEN-th accept: clear op_cnt, go to WAIT_ACK.
  - op_ready low: hold op_data stable; no pop.
- WAIT_ACK:
  - op_valid=0.
  - grp_fail=1 takes priority over grp_done:
    - If retry_cnt < MAX_RETRY: q_reset=1 for one cycle, retry_cnt+1, go to REWIND.
    - Otherwise: set error=1, go to HALT.
  - grp_done=1 (fail=0): q_next=1 for one cycle, retry_cnt=0, go to IDLE.
- REWIND:
  - One cycle so the queue's read pointer and q_data settle.
  - Then go to ISSUE. Replays the identical GROUP_LEN ops.
- HALT:
  - All handshake outputs 0; error held.
  - Exits only via rst.
- grp_done / grp_fail outside WAIT_ACK are ignored.
- q_pop, q_next and q_reset are mutually exclusive in every cycle.
- No pointer arithmetic here. Queue wrap-around is transparent.
- q_empty is not re-sampled in ISSUE: GROUP_LEN entries are guaranteed beyond the checkpoint.
- rst mid-group: everything returns to IDLE.
  - Pops not committed via q_next remain replayable only if the queue itself is not reset.
  - The system resets both together.
- Throughput: with op_ready tied high, one op per cycle. A group occupies GROUP_LEN cycles plus ack latency, plus 1 IDLE cycle.

Optional Feature:
- Macro: READER_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(ACK_TIMEOUT+1) runs in WAIT_ACK and clears on entry.
  - Reaching ACK_TIMEOUT with no grp_done/grp_fail is treated exactly as grp_fail (rewind or error).
  - A grp_done/grp_fail arriving in the timeout cycle takes precedence over the timeout.
- Undefined: no counter. WAIT_ACK waits indefinitely.

Test Plan:
- Commit path: queue holds ops 0x11,0x22,0x33,0x44; op_ready=1.
  - Required: op_data 0x11..0x44 on 4 consecutive cycles with q_pop=1 each.
  - Then grp_done → q_next pulse for 1 cycle, busy=0.
- Backpressure: op_ready=0 for 3 cycles on op 2.
  - Required: op_data held at 0x22, q_pop=0 during the stall.
  - Sequence completes unchanged after release.
- Replay: grp_fail after the group.
  - Required: q_reset pulse, 1 REWIND cycle, then 0x11..0x44 re-issued.
  - Then grp_done → q_next; retry_cnt back to 0.
- Retry exhaustion: 4 consecutive grp_fail (MAX_RETRY=3).
  - Required: 3 replays, then error=1, state HALT.
  - No further q_pop/q_reset; cleared only by rst.
- Priority and async reset:
  - grp_done and grp_fail in the same cycle → rewind, not commit.
  - rst asserted mid-ISSUE (after 2 ops) → outputs 0 immediately; IDLE after release.
- Timeout (READER_TIMEOUT_EN, ACK_TIMEOUT=8):
  - No ack for 8 cycles → q_reset pulse and replay.
  - Without the macro: still in WAIT_ACK at cycle 100.
